// File: rtl/datapath_param.sv
// Multi-cycle CPU datapath: register file, ALU, PC/LR/IR/ALUOUT, latched flags,
// muxed system bus with conflict detection, and a hardware interrupt-entry sequencer.
module datapath_param #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned NREGS      = 8,
    parameter logic [15:0] INT_VECTOR = 16'h0010,
    localparam int unsigned RA_W      = $clog2(NREGS)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] SysBus,
    output logic              SysBusValid,
    output logic              BusErr,
    output logic [7:0]        Opcode,
    output logic [3:0]        Flags,
    input  logic [3:0]        AluOp,
    input  logic              Op1Sel,
    input  logic              Op2Sel,
    input  logic              ImmSel,
    input  logic [1:0]        PcSel,
    input  logic              LrSel,
    input  logic              WdSel,
    input  logic [RA_W-1:0]   Rs1,
    input  logic [RA_W-1:0]   Rs2,
    input  logic [RA_W-1:0]   Rw,
    input  logic              PcWe,
    input  logic              LrWe,
    input  logic              IrWe,
    input  logic              RegWe,
    input  logic              AluWe,
    input  logic              FlagWe,
    input  logic              MemEn,
    input  logic              AluEn,
    input  logic              PcEn,
    input  logic              LrEn,
    input  logic              FlagEn,
    input  logic              IntReq,
    input  logic              Boundary,
    input  logic              IeSet,
    input  logic              IeClr,
    input  logic              Reti,
    output logic              IntAck,
    output logic              Stall,
    output logic              IntEn
);

    localparam int unsigned MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] VECTOR = DATA_W'(INT_VECTOR);
    localparam logic [DATA_W-1:0] ONE    = DATA_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SAVE,
        S_VECT
    } seq_e;

    seq_e seq_q, seq_d;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] lr_q, lr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] aluout_q, aluout_d;
    logic [DATA_W-1:0] epc_q, epc_d;
    logic [3:0]        flag_q, flag_d;
    logic [3:0]        eflags_q, eflags_d;
    logic              ie_q, ie_d;
    logic              buserr_q, buserr_d;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic              seq_save;
    logic              seq_vect;
    logic              stall;
    logic              int_take;
    logic              reti_go;

    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] op1, op2;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] bus;
    logic [4:0]        drv_en;
    logic              bus_conflict;

    logic [DATA_W-1:0] add_b;
    logic              add_cin;
    logic [DATA_W:0]   add_sum;
    logic              add_v;
    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        alu_flags;

    // ------------------------------------------------------------------
    // Interrupt-entry sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            seq_q <= S_IDLE;
        end else begin
            seq_q <= seq_d;
        end
    end

    assign int_take = IntReq & ie_q & Boundary & ~Reti;

    always_comb begin
        seq_d = seq_q;
        case (seq_q)
            S_IDLE:  if (int_take) seq_d = S_SAVE;
            S_SAVE:  seq_d = S_VECT;
            S_VECT:  seq_d = S_IDLE;
            default: seq_d = S_IDLE;
        endcase
    end

    always_comb begin
        seq_save = 1'b0;
        seq_vect = 1'b0;
        stall    = 1'b0;
        case (seq_q)
            S_SAVE: begin
                seq_save = 1'b1;
                stall    = 1'b1;
            end
            S_VECT: begin
                seq_vect = 1'b1;
                stall    = 1'b1;
            end
            default: ;
        endcase
    end

    // Stall is only high outside IDLE, so Reti is implicitly IDLE-only.
    assign reti_go = Reti & ~stall;

    // ------------------------------------------------------------------
    // Register file, operand selection
    // ------------------------------------------------------------------
    assign rd1 = regs_q[Rs1];
    assign rd2 = regs_q[Rs2];

    assign imm = ImmSel ? DATA_W'(signed'(ir_q[7:0])) : DATA_W'(signed'(ir_q[4:0]));
    assign op1 = Op1Sel ? pc_q : rd1;
    assign op2 = Op2Sel ? imm : rd2;

    assign pc_inc = pc_q + ONE;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (RegWe && !stall) begin
            regs_q[Rw] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // ALU: subtracts are done as op1 + ~op2 + cin, so C is NOT borrow
    // ------------------------------------------------------------------
    always_comb begin
        add_b   = op2;
        add_cin = 1'b0;
        case (AluOp)
            4'd1: add_cin = flag_q[1];
            4'd2: begin
                add_b   = ~op2;
                add_cin = 1'b1;
            end
            4'd3: begin
                add_b   = ~op2;
                add_cin = flag_q[1];
            end
            default: ;
        endcase
    end

    assign add_sum = {1'b0, op1} + {1'b0, add_b} + (DATA_W+1)'(add_cin);
    assign add_v   = (op1[MSB] == add_b[MSB]) && (add_sum[MSB] != op1[MSB]);

    always_comb begin
        alu_res = op1;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (AluOp)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                alu_res = add_sum[DATA_W-1:0];
                alu_c   = add_sum[DATA_W];
                alu_v   = add_v;
            end
            4'd4: alu_res = op1 & op2;
            4'd5: alu_res = op1 | op2;
            4'd6: alu_res = op1 ^ op2;
            4'd7: alu_res = ~op1;
            4'd8: begin
                alu_res = {op1[MSB-1:0], 1'b0};
                alu_c   = op1[MSB];
            end
            4'd9: begin
                alu_res = {1'b0, op1[MSB:1]};
                alu_c   = op1[0];
            end
            4'd10: begin
                alu_res = {op1[MSB], op1[MSB:1]};
                alu_c   = op1[0];
            end
            4'd11: alu_res = op2;
            default: alu_res = op1;
        endcase
    end

    assign alu_flags = {(alu_res == '0), alu_res[MSB], alu_c, alu_v};

    // ------------------------------------------------------------------
    // System bus
    // ------------------------------------------------------------------
    assign drv_en       = {MemEn, AluEn, PcEn, LrEn, FlagEn};
    assign bus_conflict = (drv_en & (drv_en - 5'd1)) != 5'd0;

    always_comb begin
        bus = '0;
        if (MemEn) begin
            bus = DataIn;
        end else if (AluEn) begin
            bus = aluout_q;
        end else if (PcEn) begin
            bus = pc_q;
        end else if (LrEn) begin
            bus = lr_q;
        end else if (FlagEn) begin
            bus = DATA_W'(flag_q);
        end
    end

    assign wdata = WdSel ? bus : alu_res;

    // ------------------------------------------------------------------
    // Architectural registers
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (seq_vect) begin
            pc_d = VECTOR;
        end else if (reti_go) begin
            pc_d = epc_q;
        end else if (PcWe && !stall) begin
            case (PcSel)
                2'd0:    pc_d = pc_inc;
                2'd1:    pc_d = alu_res;
                2'd2:    pc_d = bus;
                default: pc_d = lr_q;
            endcase
        end
    end

    always_comb begin
        lr_d = lr_q;
        if (LrWe && !stall) begin
            lr_d = LrSel ? bus : pc_inc;
        end
    end

    always_comb begin
        ir_d     = ir_q;
        aluout_d = aluout_q;
        if (!stall) begin
            if (IrWe) ir_d = bus;
            if (AluWe) aluout_d = alu_res;
        end
    end

    always_comb begin
        flag_d = flag_q;
        if (reti_go) begin
            flag_d = eflags_q;
        end else if (FlagWe && !stall) begin
            flag_d = alu_flags;
        end
    end

    always_comb begin
        epc_d    = epc_q;
        eflags_d = eflags_q;
        if (seq_save) begin
            epc_d    = pc_q;
            eflags_d = flag_q;
        end
    end

    // Reti outranks IeClr/IeSet; the sequencer's clear outranks everything.
    always_comb begin
        ie_d = ie_q;
        if (seq_save) begin
            ie_d = 1'b0;
        end else if (!stall) begin
            if (reti_go) begin
                ie_d = 1'b1;
            end else if (IeClr) begin
                ie_d = 1'b0;
            end else if (IeSet) begin
                ie_d = 1'b1;
            end
        end
    end

    assign buserr_d = buserr_q | bus_conflict;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q     <= '0;
            lr_q     <= '0;
            ir_q     <= '0;
            aluout_q <= '0;
            epc_q    <= '0;
            flag_q   <= '0;
            eflags_q <= '0;
            ie_q     <= 1'b0;
            buserr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            lr_q     <= lr_d;
            ir_q     <= ir_d;
            aluout_q <= aluout_d;
            epc_q    <= epc_d;
            flag_q   <= flag_d;
            eflags_q <= eflags_d;
            ie_q     <= ie_d;
            buserr_q <= buserr_d;
        end
    end

    assign SysBus      = bus;
    assign SysBusValid = |drv_en;
    assign BusErr      = buserr_q;
    assign Opcode      = ir_q[DATA_W-1 -: 8];
    assign Flags       = flag_q;
    assign IntAck      = seq_vect;
    assign Stall       = stall;
    assign IntEn       = ie_q;

endmodule

// File: tb/tb_datapath_param.sv
// Directed-vector bench for datapath_param: a 16-bit/8-register instance for the
// main checks and a 32-bit/16-register instance for the wide register-file case.
module tb_datapath_param;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] DataIn;
    logic [31:0] DataIn32;
    logic [3:0]  AluOp;
    logic        Op1Sel, Op2Sel, ImmSel, LrSel, WdSel;
    logic [1:0]  PcSel;
    logic [2:0]  Rs1, Rs2, Rw;
    logic [3:0]  Rs1_32, Rs2_32, Rw_32;
    logic        PcWe, LrWe, IrWe, RegWe, AluWe, FlagWe;
    logic        MemEn, AluEn, PcEn, LrEn, FlagEn;
    logic        IntReq, Boundary, IeSet, IeClr, Reti;

    logic [15:0] SysBus;
    logic        SysBusValid, BusErr, IntAck, Stall, IntEn;
    logic [7:0]  Opcode;
    logic [3:0]  Flags;

    logic [31:0] SysBus32;
    logic        SysBusValid32, BusErr32, IntAck32, Stall32, IntEn32;
    logic [7:0]  Opcode32;
    logic [3:0]  Flags32;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 Clock = ~Clock;

    datapath_param #(.DATA_W(16), .NREGS(8), .INT_VECTOR(16'h0010)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn),
        .SysBus(SysBus), .SysBusValid(SysBusValid), .BusErr(BusErr),
        .Opcode(Opcode), .Flags(Flags),
        .AluOp(AluOp), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .ImmSel(ImmSel),
        .PcSel(PcSel), .LrSel(LrSel), .WdSel(WdSel),
        .Rs1(Rs1), .Rs2(Rs2), .Rw(Rw),
        .PcWe(PcWe), .LrWe(LrWe), .IrWe(IrWe), .RegWe(RegWe), .AluWe(AluWe), .FlagWe(FlagWe),
        .MemEn(MemEn), .AluEn(AluEn), .PcEn(PcEn), .LrEn(LrEn), .FlagEn(FlagEn),
        .IntReq(IntReq), .Boundary(Boundary), .IeSet(IeSet), .IeClr(IeClr), .Reti(Reti),
        .IntAck(IntAck), .Stall(Stall), .IntEn(IntEn)
    );

    datapath_param #(.DATA_W(32), .NREGS(16)) dut32 (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn32),
        .SysBus(SysBus32), .SysBusValid(SysBusValid32), .BusErr(BusErr32),
        .Opcode(Opcode32), .Flags(Flags32),
        .AluOp(AluOp), .Op1Sel(Op1Sel), .Op2Sel(Op2Sel), .ImmSel(ImmSel),
        .PcSel(PcSel), .LrSel(LrSel), .WdSel(WdSel),
        .Rs1(Rs1_32), .Rs2(Rs2_32), .Rw(Rw_32),
        .PcWe(PcWe), .LrWe(LrWe), .IrWe(IrWe), .RegWe(RegWe), .AluWe(AluWe), .FlagWe(FlagWe),
        .MemEn(MemEn), .AluEn(AluEn), .PcEn(PcEn), .LrEn(LrEn), .FlagEn(FlagEn),
        .IntReq(IntReq), .Boundary(Boundary), .IeSet(IeSet), .IeClr(IeClr), .Reti(Reti),
        .IntAck(IntAck32), .Stall(Stall32), .IntEn(IntEn32)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        DataIn = '0; DataIn32 = '0; AluOp = '0;
        Op1Sel = 0; Op2Sel = 0; ImmSel = 0; LrSel = 0; WdSel = 0; PcSel = '0;
        Rs1 = '0; Rs2 = '0; Rw = '0; Rs1_32 = '0; Rs2_32 = '0; Rw_32 = '0;
        PcWe = 0; LrWe = 0; IrWe = 0; RegWe = 0; AluWe = 0; FlagWe = 0;
        MemEn = 0; AluEn = 0; PcEn = 0; LrEn = 0; FlagEn = 0;
        IntReq = 0; Boundary = 0; IeSet = 0; IeClr = 0; Reti = 0;
    endtask

    task automatic wr16(input logic [2:0] r, input logic [15:0] v);
        idle();
        MemEn = 1; WdSel = 1; RegWe = 1; Rw = r; DataIn = v;
        tick();
        idle();
    endtask

    task automatic alu(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
        idle();
        AluOp = op; Rs1 = a; Rs2 = b; AluWe = 1; FlagWe = 1;
        tick();
        idle();
    endtask

    task automatic aluout_is(input string tag, input logic [15:0] exp);
        idle();
        AluEn = 1;
        #1 chk(tag, SysBus, exp);
        AluEn = 0;
    endtask

    task automatic pc_is(input string tag, input logic [15:0] exp);
        idle();
        PcEn = 1;
        #1 chk(tag, SysBus, exp);
        PcEn = 0;
    endtask

    task automatic load_pc(input logic [15:0] v);
        idle();
        MemEn = 1; DataIn = v; PcSel = 2'd2; PcWe = 1;
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        Reset = 1;
        tick(); tick();
        Reset = 0;
        chk("rst_stall", Stall, 0);
        chk("rst_intack", IntAck, 0);
        chk("rst_ie", IntEn, 0);
        chk("rst_buserr", BusErr, 0);
        chk("rst_flags", Flags, 0);
        chk("rst_valid", SysBusValid, 0);
        chk("rst_bus", SysBus, 0);
        pc_is("rst_pc", 16'h0000);

        // Wide instance: R15 write/read, R7 untouched
        idle();
        MemEn = 1; WdSel = 1; RegWe = 1; Rw_32 = 4'd15; DataIn32 = 32'hDEADBEEF;
        tick();
        idle(); Rs1_32 = 4'd15; AluOp = 4'd12; AluWe = 1;
        tick();
        idle(); AluEn = 1;
        #1 chk("w32_r15", SysBus32, 32'hDEADBEEF);
        idle(); Rs1_32 = 4'd7; AluOp = 4'd12; AluWe = 1;
        tick();
        idle(); AluEn = 1;
        #1 chk("w32_r7", SysBus32, 32'h0);

        // ALU and flags
        wr16(3'd1, 16'h7FFF);
        wr16(3'd2, 16'h0001);
        alu(4'd0, 3'd1, 3'd2);
        chk("add_flags", Flags, 4'b0101);
        aluout_is("add_res", 16'h8000);
        alu(4'd2, 3'd2, 3'd2);
        chk("sub_flags", Flags, 4'b1010);
        aluout_is("sub_res", 16'h0000);
        alu(4'd1, 3'd1, 3'd2);
        chk("adc_flags", Flags, 4'b0101);
        aluout_is("adc_res", 16'h8001);
        wr16(3'd3, 16'h8001);
        alu(4'd10, 3'd3, 3'd3);
        chk("asr_flags", Flags, 4'b0110);
        aluout_is("asr_res", 16'hC000);
        idle(); FlagEn = 1;
        #1 chk("flag_bus", SysBus, 16'h0006);

        // IR, opcode and immediates
        idle(); MemEn = 1; DataIn = 16'hAB12; IrWe = 1;
        tick();
        chk("opcode", Opcode, 8'hAB);
        idle(); Op2Sel = 1; ImmSel = 0; AluOp = 4'd11; AluWe = 1;
        tick();
        aluout_is("imm5", 16'hFFF2);
        idle(); Op2Sel = 1; ImmSel = 1; AluOp = 4'd11; AluWe = 1;
        tick();
        aluout_is("imm8", 16'h0012);

        // PC wrap
        load_pc(16'hFFFF);
        pc_is("pc_ffff", 16'hFFFF);
        idle(); PcWe = 1; PcSel = 2'd0;
        tick();
        pc_is("pc_wrap", 16'h0000);
        PcEn = 1;
        #1 chk("pc_valid", SysBusValid, 1);
        idle();
        #1 chk("idle_valid", SysBusValid, 0);

        // Bus conflict
        chk("buserr_pre", BusErr, 0);
        idle(); MemEn = 1; AluEn = 1; DataIn = 16'hA5A5;
        #1 chk("conflict_bus", SysBus, 16'hA5A5);
        tick();
        idle();
        chk("buserr_set", BusErr, 1);
        repeat (10) tick();
        chk("buserr_sticky", BusErr, 1);

        // Interrupt entry and return
        load_pc(16'h0042);
        chk("int_flags_pre", Flags, 4'b0110);
        idle(); IeSet = 1;
        tick();
        idle();
        chk("ie_set", IntEn, 1);
        IntReq = 1; Boundary = 1;
        tick();
        chk("int_c1_stall", Stall, 1);
        chk("int_c1_ack", IntAck, 0);
        MemEn = 1; WdSel = 1; DataIn = 16'h1234; RegWe = 1; Rw = 3'd1;
        PcWe = 1; PcSel = 2'd2; FlagWe = 1;
        tick();
        chk("int_c2_stall", Stall, 1);
        chk("int_c2_ack", IntAck, 1);
        chk("int_c2_ie", IntEn, 0);
        tick();
        idle();
        chk("int_done_stall", Stall, 0);
        chk("int_done_ack", IntAck, 0);
        chk("int_done_flags", Flags, 4'b0110);
        pc_is("int_vector", 16'h0010);
        idle(); Rs1 = 3'd1; AluOp = 4'd12; AluWe = 1;
        tick();
        aluout_is("int_r1_kept", 16'h7FFF);
        alu(4'd2, 3'd2, 3'd2);
        chk("isr_flags", Flags, 4'b1010);
        idle(); Reti = 1;
        tick();
        idle();
        chk("reti_flags", Flags, 4'b0110);
        chk("reti_ie", IntEn, 1);
        chk("reti_stall", Stall, 0);
        pc_is("reti_pc", 16'h0042);

        // Reset in the middle of VECT
        idle(); IntReq = 1; Boundary = 1;
        tick();
        tick();
        chk("vect_ack", IntAck, 1);
        idle(); Reset = 1;
        tick();
        Reset = 0;
        chk("mrst_stall", Stall, 0);
        chk("mrst_ack", IntAck, 0);
        chk("mrst_ie", IntEn, 0);
        chk("mrst_buserr", BusErr, 0);
        pc_is("mrst_pc", 16'h0000);

        // IE priority and old-IE gating
        idle(); IeSet = 1; IeClr = 1;
        tick();
        idle();
        chk("ie_clr_wins", IntEn, 0);
        IeSet = 1; IntReq = 1; Boundary = 1;
        tick();
        chk("ieset_no_take", Stall, 0);
        chk("ieset_ie", IntEn, 1);
        IeSet = 0;
        tick();
        chk("ieset_then_take", Stall, 1);
        idle();
        tick();
        tick();
        chk("take2_stall", Stall, 0);
        pc_is("take2_pc", 16'h0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/datapath_param.md
Name: datapath_param

Overview:
- Second-generation multi-cycle CPU datapath, parametrised in data width and register count.
- Contains: register file, ALU, PC, LR, IR, ALU-out register, a latched flags register, and a single muxed system bus with driver-conflict detection.
- New relative to the previous datapath: hardware interrupt-entry sequencer with shadow EPC/EFLAGS, a one-cycle return-from-interrupt, and a sticky bus-error flag.
- Sits between the control FSM and the memory interface.

Parameters:
- DATA_W, 16, width of the bus, registers and ALU; minimum 8.
- NREGS, 8, number of general registers; power of 2, minimum 2. RA_W = clog2(NREGS).
- INT_VECTOR, 16'h0010, PC value loaded on interrupt entry, truncated/zero-extended to DATA_W.

Ports:
- Clock in 1: rising-edge clock.
- Reset in 1: synchronous, active-high reset.
- DataIn in DATA_W: memory read data.
- SysBus out DATA_W: muxed system bus.
- SysBusValid out 1: high when at least one bus driver is enabled.
- BusErr out 1: sticky bus-conflict flag.
- Opcode out 8: Ir[DATA_W-1 -: 8].
- Flags out 4: latched flags {Z,N,C,V} (FlagReg).
- AluOp in 4: ALU function.
- Op1Sel in 1: 0 = Rd1, 1 = PC.
- Op2Sel in 1: 0 = Rd2, 1 = immediate.
- ImmSel in 1: 0 = sign-extend Ir[4:0], 1 = sign-extend Ir[7:0].
- PcSel in 2: 0 = PC+1, 1 = ALU result, 2 = SysBus, 3 = LR.
- LrSel in 1: 0 = PC+1, 1 = SysBus.
- WdSel in 1: 0 = ALU result, 1 = SysBus.
- Rs1, Rs2, Rw in RA_W each: register-file addresses.
- PcWe, LrWe, IrWe, RegWe, AluWe, FlagWe in 1 each: register write enables.
- MemEn, AluEn, PcEn, LrEn, FlagEn in 1 each: bus driver enables.
- IntReq in 1: level interrupt request.
- Boundary in 1: controller is at an instruction boundary.
- IeSet, IeClr in 1 each: set / clear the interrupt-enable bit.
- Reti in 1: return from interrupt.
- IntAck out 1: one-cycle pulse on vector load.
- Stall out 1: high while the sequencer owns the datapath.
- IntEn out 1: current interrupt-enable bit.

Behaviour:
- Reset (synchronous, active-high): on a Reset clock edge all of the following clear to 0, with the sequencer forced to IDLE even mid-sequence:
  - PC, LR, IR, ALUOUT, every register, FlagReg, EPC, EFLAGS
  - IE, BusErr, IntAck, Stall
- Register file:
  - Two asynchronous reads (Rd1 = R[Rs1], Rd2 = R[Rs2]); one synchronous write R[Rw] <= WData when RegWe.
  - A same-cycle read of Rw returns the old value.
- ALU is combinational; Result and flags are computed modulo 2^DATA_W. Encodings:
  - 0 ADD, 1 ADC (carry in = FlagReg.C), 2 SUB, 3 SBC (Op1-Op2-!C)
  - 4 AND, 5 OR, 6 XOR, 7 NOT Op1
  - 8 LSL1, 9 LSR1, 10 ASR1, 11 pass Op2; 12-15 pass Op1
- ALU flags:
  - Z: result == 0. N: result MSB.
  - C: carry-out for add; NOT borrow for subtract; shifted-out bit for shifts; 0 for all other ops.
  - V: signed overflow for add/sub; 0 otherwise.
- FlagReg loads the ALU flags on FlagWe.
- PC+1 wraps from all-ones to 0.
- SysBus driver priority is MemEn > AluEn > PcEn > LrEn > FlagEn.
  - The driven value is DataIn, ALUOUT, PC, LR, or {0..,FlagReg} respectively.
  - With no driver enabled, SysBus = 0 and SysBusValid = 0.
  - If two or more drivers are enabled in a cycle, BusErr is set on the next edge and stays set until Reset; the highest-priority driver still wins.
- IR, LR, PC and ALUOUT load on their We on the rising edge.
- Interrupt sequencer: states IDLE, SAVE, VECT.
  - IDLE -> SAVE when IntReq & IE & Boundary & !Reti.
  - SAVE (Stall = 1): EPC <= PC, EFLAGS <= FlagReg, IE <= 0.
  - VECT (Stall = 1, IntAck = 1): PC <= INT_VECTOR; then return to IDLE.
  - Entry latency: 2 cycles from the qualifying edge to PC = vector.
- While Stall is high:
  - All external We inputs, IeSet/IeClr and Reti are ignored.
  - Bus drive continues normally.
- Reti (IDLE only), in one cycle:
  - PC <= EPC, FlagReg <= EFLAGS, IE <= 1.
  - Overrides PcWe/FlagWe in that cycle.
  - Any pending interrupt is evaluated from the following cycle.
- IE updates:
  - IeSet and IeClr together: IeClr wins.
  - IeSet in the same cycle as a qualifying interrupt: the interrupt is not taken that cycle, because the old IE value is used.
- A new IntReq during SAVE/VECT is not re-evaluated until IDLE, and is then gated by IE = 0.

Test Plan:
- Reset mid-VECT, then release -> next cycle PC = 0, Stall = 0, IntAck = 0, IE = 0, state IDLE.
- DATA_W = 16: R1 = 16'h7FFF, R2 = 1, AluOp = ADD, FlagWe -> result 16'h8000; Flags Z = 0, N = 1, C = 0, V = 1. Then SUB R2-R2 -> Z = 1, C = 1.
- PC = 16'hFFFF, PcSel = 0, PcWe -> PC = 0. With PcEn alone, SysBus = 16'h0000 and SysBusValid = 1.
- MemEn and AluEn high for one cycle with DataIn = 16'hA5A5 -> SysBus = 16'hA5A5; BusErr = 1 next cycle and remains 1 for 10 idle cycles.
- IE = 1, PC = 16'h0042, FlagReg = 4'b0110, IntReq & Boundary:
  - Cycle +1: Stall = 1.
  - Cycle +2: IntAck = 1, and PC = 16'h0010 after that edge.
  - Concurrent RegWe during these cycles: no register changes.
  - Then Reti -> PC = 16'h0042, Flags = 4'b0110, IE = 1.
- NREGS = 16, DATA_W = 32: write R15 = 32'hDEADBEEF, read via Rs1 = 15 -> Rd1 (via pass-Op1) = 32'hDEADBEEF; R7 remains 0.
